// File: rtl/gate_sched_pkg.sv
// -----------------------------------------------------------------------------
// gate_sched_pkg
//   Shared types and helpers for the parking-lot gate scheduler.
//   gs_state_t   : scheduler FSM states
//   gs_grant_t   : which gate received the most recent grant (round-robin memory)
//   TIMER_W      : width of the shared hold/guard down-counter
//   reload_value : converts a cycle count into the value loaded into the timer
// -----------------------------------------------------------------------------
package gate_sched_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_ENT = 2'd1,
        OPEN_EXT = 2'd2,
        GUARD    = 2'd3
    } gs_state_t;

    typedef enum logic {
        GRANT_ENT = 1'b0,
        GRANT_EXT = 1'b1
    } gs_grant_t;

    // The timer counts down to zero inclusive, so a window of N cycles loads N-1.
    function automatic logic [TIMER_W-1:0] reload_value(input int unsigned cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/gate_scheduler_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
//   32-bit down-counter shared by the open window and the guard interval.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous, active-high reset (count -> 0)
//     load       in   load load_value this cycle (takes priority over counting)
//     load_value in   value to load
//     expired    out  count == 0; the counter holds at zero once it gets there
// -----------------------------------------------------------------------------
module hold_timer
    import gate_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!expired) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/gate_scheduler.sv
// -----------------------------------------------------------------------------
// gate_scheduler
//   Arbitrates a single car lane between the entrance and exit gates of the
//   parking simulator. One gate is granted at a time and held open for
//   HOLD_CYCLES or until the car passes, followed by GUARD_CYCLES with both
//   gates closed. Lot occupancy is tracked and entry is refused when full.
//
//   Optional feature macro: GATE_SCHED_STATS_EN
//     defined   -> adds total_in / total_out saturating pass counters
//     undefined -> those ports and counters are absent
//
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous, active-high reset
//     ent_req    in   level: car waiting at entrance
//     ext_req    in   level: car waiting at exit
//     pass       in   1-cycle pulse: car cleared the currently open gate
//     ent_open   out  entrance gate drive (registered)
//     ext_open   out  exit gate drive (registered)
//     busy       out  scheduler not idle
//     full       out  occupancy == CAPACITY
//     occupancy  out  cars currently in the lot
//     total_in   out  accepted entrance passes, saturating (stats build only)
//     total_out  out  accepted exit passes, saturating (stats build only)
// -----------------------------------------------------------------------------
module gate_scheduler
    import gate_sched_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned GUARD_CYCLES = 5_000_000,
    parameter int unsigned CAPACITY     = 3,
    localparam int CNT_W = $clog2(CAPACITY + 1)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             ent_req,
    input  logic             ext_req,
    input  logic             pass,
    output logic             ent_open,
    output logic             ext_open,
    output logic             busy,
    output logic             full,
    output logic [CNT_W-1:0] occupancy
`ifdef GATE_SCHED_STATS_EN
    ,
    output logic [15:0]      total_in,
    output logic [15:0]      total_out
`endif
);

    gs_state_t          state, state_d;
    gs_grant_t          last_grant, last_grant_d;
    logic [CNT_W-1:0]   occupancy_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;
    logic               ent_ok, ext_ok;

    hold_timer u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    assign full   = (occupancy == CNT_W'(CAPACITY));
    assign busy   = (state != IDLE);
    // Eligibility alone keeps occupancy inside [0, CAPACITY].
    assign ent_ok = ent_req && !full;
    assign ext_ok = ext_req && (occupancy != '0);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        occupancy_d  = occupancy;
        timer_load   = 1'b0;
        timer_value  = '0;
        case (state)
            IDLE: begin
                // With both sides eligible, grant the side that did not go last.
                if (ent_ok && (!ext_ok || last_grant == GRANT_EXT)) begin
                    state_d      = OPEN_ENT;
                    last_grant_d = GRANT_ENT;
                    timer_load   = 1'b1;
                    timer_value  = reload_value(HOLD_CYCLES);
                end else if (ext_ok) begin
                    state_d      = OPEN_EXT;
                    last_grant_d = GRANT_EXT;
                    timer_load   = 1'b1;
                    timer_value  = reload_value(HOLD_CYCLES);
                end
            end
            OPEN_ENT, OPEN_EXT: begin
                // pass is tested first so a car clearing on the expiry cycle is counted.
                if (pass || timer_expired) begin
                    state_d     = GUARD;
                    timer_load  = 1'b1;
                    timer_value = reload_value(GUARD_CYCLES);
                end
                if (pass) begin
                    occupancy_d = (state == OPEN_ENT) ? occupancy + CNT_W'(1)
                                                      : occupancy - CNT_W'(1);
                end
            end
            GUARD: begin
                if (timer_expired) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_EXT;
            occupancy  <= '0;
            ent_open   <= 1'b0;
            ext_open   <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            occupancy  <= occupancy_d;
            // Drives are decoded from the next state so they track the FSM exactly.
            ent_open   <= (state_d == OPEN_ENT);
            ext_open   <= (state_d == OPEN_EXT);
        end
    end

`ifdef GATE_SCHED_STATS_EN
    logic acc_in, acc_out;
    assign acc_in  = (state == OPEN_ENT) && pass;
    assign acc_out = (state == OPEN_EXT) && pass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_in  <= '0;
            total_out <= '0;
        end else begin
            if (acc_in && total_in != 16'hFFFF) begin
                total_in <= total_in + 16'd1;
            end
            if (acc_out && total_out != 16'hFFFF) begin
                total_out <= total_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gate_scheduler
//   Self-checking bench for gate_scheduler (HOLD=8, GUARD=2, CAPACITY=2).
//   A cycle-level reference model tracks which gate is open, how long it has
//   been open, remaining guard cycles and the car count; each scenario task
//   compares the DUT against it and against fixed scenario expectations.
// -----------------------------------------------------------------------------
module tb_gate_scheduler;

    localparam int HOLD  = 8;
    localparam int GUARD = 2;
    localparam int CAP   = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset, ent_req, ext_req, pass;
    logic             ent_open, ext_open, busy, full;
    logic [CNT_W-1:0] occupancy;
`ifdef GATE_SCHED_STATS_EN
    logic [15:0]      total_in, total_out;
`endif

    int checks   = 0;
    int failures = 0;

    gate_scheduler #(
        .HOLD_CYCLES  (HOLD),
        .GUARD_CYCLES (GUARD),
        .CAPACITY     (CAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ent_req   (ent_req),
        .ext_req   (ext_req),
        .pass      (pass),
        .ent_open  (ent_open),
        .ext_open  (ext_open),
        .busy      (busy),
        .full      (full),
        .occupancy (occupancy)
`ifdef GATE_SCHED_STATS_EN
        ,
        .total_in  (total_in),
        .total_out (total_out)
`endif
    );

    always #5 clk = ~clk;

    wire [5:0] dut_vec = {ent_open, ext_open, busy, full, occupancy};

    // ---------------- reference model ----------------
    int m_gate;      // 0 none, 1 entrance, 2 exit
    int m_age;       // cycles the current gate has been open
    int m_guard;     // guard cycles still to run
    int m_occ;
    bit m_last_ent;  // last grant went to the entrance
    int m_in, m_out;

    function automatic void model_reset();
        m_gate = 0; m_age = 0; m_guard = 0; m_occ = 0;
        m_last_ent = 1'b0; m_in = 0; m_out = 0;
    endfunction

    function automatic void model_step(input bit rst, input bit e, input bit x, input bit p);
        bit e_ok, x_ok;
        if (rst) begin
            model_reset();
        end else if (m_gate != 0) begin
            m_age++;
            if (p) begin
                if (m_gate == 1) begin m_occ++; m_in++; end
                else             begin m_occ--; m_out++; end
                m_gate  = 0;
                m_guard = GUARD;
            end else if (m_age == HOLD) begin
                m_gate  = 0;
                m_guard = GUARD;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else begin
            e_ok = e && (m_occ < CAP);
            x_ok = x && (m_occ > 0);
            if (e_ok && (!x_ok || !m_last_ent)) begin
                m_gate = 1; m_age = 0; m_last_ent = 1'b1;
            end else if (x_ok) begin
                m_gate = 2; m_age = 0; m_last_ent = 1'b0;
            end
        end
    endfunction

    function automatic logic [5:0] exp_vec();
        logic m_busy;
        m_busy = (m_gate != 0) || (m_guard > 0);
        return {m_gate == 1, m_gate == 2, m_busy, m_occ == CAP, CNT_W'(m_occ)};
    endfunction

    // Advance one clock: model sees the same inputs the DUT samples, outputs settle by #1.
    task automatic tick();
        @(posedge clk);
        model_step(reset, ent_req, ext_req, pass);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; ent_req = 1'b0; ext_req = 1'b0; pass = 1'b0;
        model_reset();
        tick(); tick();
        checks++;
        if (dut_vec !== 6'b000000) begin
            failures++;
            $display("FAIL reset_state got=%b want=000000", dut_vec);
        end
    endtask

    task automatic test_pass_early();
        int open_cnt = 0, guard_cnt = 0;
        bit closed = 0, regrant = 0;
        reset = 1'b0; ent_req = 1'b1;
        for (int c = 0; c < 40 && !regrant; c++) begin
            pass = (m_gate == 1 && m_age == 2 && !closed);
            tick();
            pass = 1'b0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL pass_early_cycle%0d got=%b want=%b", c, dut_vec, exp_vec());
            end
            if (ent_open && !closed) open_cnt++;
            else if (ent_open) regrant = 1;
            else if (open_cnt > 0) begin closed = 1; if (busy) guard_cnt++; end
        end
        checks++;
        if (open_cnt !== 3) begin failures++; $display("FAIL pass_early_open got=%0d want=3", open_cnt); end
        checks++;
        if (guard_cnt !== GUARD) begin failures++; $display("FAIL pass_early_guard got=%0d want=%0d", guard_cnt, GUARD); end
        checks++;
        if (!regrant || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL pass_early_regrant regrant=%0d occ=%0d want regrant=1 occ=1", regrant, occupancy);
        end
    endtask

    task automatic test_timeout();
        int open_cnt, guard_cnt = 0;
        open_cnt = ent_open ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_cycle%0d got=%b want=%b", c, dut_vec, exp_vec());
            end
            if (ent_open) open_cnt++;
            else break;
        end
        if (busy && !ent_open) guard_cnt++;
        ent_req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) begin
            tick();
            if (busy) guard_cnt++;
        end
        checks++;
        if (open_cnt !== HOLD) begin failures++; $display("FAIL timeout_open got=%0d want=%0d", open_cnt, HOLD); end
        checks++;
        if (guard_cnt !== GUARD) begin failures++; $display("FAIL timeout_guard got=%0d want=%0d", guard_cnt, GUARD); end
        checks++;
        if (occupancy !== 2'd1) begin failures++; $display("FAIL timeout_occ got=%0d want=1", occupancy); end
    endtask

    task automatic test_round_robin();
        int seq[3];
        int n = 0;
        bit prev_e = 0, prev_x = 0;
        ent_req = 1'b1; ext_req = 1'b1;
        for (int c = 0; c < 60 && n < 3; c++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (ent_open && ext_open)) begin
                failures++;
                $display("FAIL rr_cycle%0d got=%b want=%b", c, dut_vec, exp_vec());
            end
            if (ent_open && !prev_e) begin seq[n] = 1; n++; end
            else if (ext_open && !prev_x) begin seq[n] = 2; n++; end
            prev_e = ent_open; prev_x = ext_open;
        end
        checks++;
        if (n != 3 || seq[0] != 2 || seq[1] != 1 || seq[2] != 2) begin
            failures++;
            $display("FAIL rr_order got n=%0d %0d,%0d,%0d want 3 2,1,2 (1=ENT 2=EXT)", n, seq[0], seq[1], seq[2]);
        end
        ent_req = 1'b0; ext_req = 1'b0;
        for (int c = 0; c < 15 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rr_settle busy got=%b want=0", busy); end
    endtask

    task automatic test_full();
        int opened = 0;
        // Bring the lot to capacity.
        ent_req = 1'b1;
        for (int c = 0; c < 20 && !ent_open; c++) tick();
        pass = 1'b1; tick(); pass = 1'b0; ent_req = 1'b0;
        for (int c = 0; c < 15 && busy; c++) tick();
        ent_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ent_open) opened++;
        end
        checks++;
        if (opened !== 0 || busy !== 1'b0 || full !== 1'b1 || occupancy !== 2'd2) begin
            failures++;
            $display("FAIL full_block opened=%0d busy=%b full=%b occ=%0d want 0 0 1 2", opened, busy, full, occupancy);
        end
        ext_req = 1'b1;
        for (int c = 0; c < 20 && !ext_open; c++) tick();
        pass = 1'b1; ext_req = 1'b0; tick(); pass = 1'b0;
        for (int c = 0; c < 20 && !(ent_open || ext_open); c++) tick();
        checks++;
        if (ent_open !== 1'b1 || ext_open !== 1'b0 || occupancy !== 2'd1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL full_release got=%b want=%b", dut_vec, exp_vec());
        end
    endtask

    // Entrance is open in its first cycle on entry; reset lands during its fourth.
    task automatic test_async_reset();
        tick(); tick(); tick();
        checks++;
        if (ent_open !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL areset_pre got=%b want=%b", dut_vec, exp_vec());
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (ent_open !== 1'b0 || occupancy !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate ent_open=%b occ=%0d busy=%b want 0 0 0", ent_open, occupancy, busy);
        end
        model_reset();
        ent_req = 1'b0;
        tick();
`ifdef GATE_SCHED_STATS_EN
        checks++;
        if (total_in !== 16'd0 || total_out !== 16'd0) begin
            failures++;
            $display("FAIL areset_stats in=%0d out=%0d want 0 0", total_in, total_out);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_pass_at_expiry();
        int open_cnt = 0;
        ent_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            pass = (m_gate == 1 && m_age == HOLD - 1);
            tick();
            pass = 1'b0;
            if (ent_open) open_cnt++;
            else if (open_cnt > 0) break;
        end
        ent_req = 1'b0;
        checks++;
        if (open_cnt !== HOLD || occupancy !== 2'd1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL expiry_pass open=%0d occ=%0d got=%b want open=8 occ=1 vec=%b", open_cnt, occupancy, dut_vec, exp_vec());
        end
        pass = 1'b1; tick(); pass = 1'b0;
        checks++;
        if (occupancy !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL guard_pass occ=%0d busy=%b want 1 1", occupancy, busy);
        end
        for (int c = 0; c < 10 && busy; c++) tick();
`ifdef GATE_SCHED_STATS_EN
        checks++;
        if (total_in !== 16'd1 || total_out !== 16'd0) begin
            failures++;
            $display("FAIL stats_in in=%0d out=%0d want 1 0", total_in, total_out);
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            ent_req = 1'($urandom_range(0, 1));
            ext_req = 1'($urandom_range(0, 1));
            pass    = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (ent_open && ext_open)) begin
                failures++;
                $display("FAIL random_cycle%0d got=%b want=%b", c, dut_vec, exp_vec());
            end
        end
        pass = 1'b0; ent_req = 1'b0; ext_req = 1'b0;
`ifdef GATE_SCHED_STATS_EN
        checks++;
        if (total_in !== 16'(m_in) || total_out !== 16'(m_out)) begin
            failures++;
            $display("FAIL random_stats in=%0d out=%0d want %0d %0d", total_in, total_out, m_in, m_out);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass_early();
        test_timeout();
        test_round_robin();
        test_full();
        test_async_reset();
        test_pass_at_expiry();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
